bscan_arbiter: RTL

Round-robin arbiter that shares one Bscan toBscan/fromBscan transaction path among NUM_REQ requesters. It sits between the Bscan wrapper and the client logic: e.g. debug CSR access, trace readout, memory peek.
- Each requester posts a WIDTH-bit word.
- The arbiter issues words to Bscan one at a time, with exactly one transaction outstanding.
- The returned word is routed back to the requester that issued it.

---
 rtl/bscan_arbiter_if.sv | 46 ++++
 rtl/bscan_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/bscan_arbiter_if.sv
// Bus bundle for bscan_arbiter: requester hold slots, the toBscan issue
// path, the fromBscan return path and the per-requester response path.
// The arbiter connects through the slave modport; the environment (clients,
// Bscan wrapper) connects through master.
interface bscan_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32
);
    logic [NUM_REQ-1:0]       req_enq__ENA;
    logic [NUM_REQ*WIDTH-1:0] req_enq__v;
    logic [NUM_REQ-1:0]       req_enq__RDY;

    logic                     bscan_enq__ENA;
    logic [WIDTH-1:0]         bscan_enq__v;
    logic                     bscan_enq__RDY;

    logic                     resp_enq__ENA;
    logic [WIDTH-1:0]         resp_enq__v;
    logic                     resp_enq__RDY;

    logic [NUM_REQ-1:0]       rsp_enq__ENA;
    logic [WIDTH-1:0]         rsp_enq__v;
    logic [NUM_REQ-1:0]       rsp_enq__RDY;

    modport slave (
        input  req_enq__ENA, req_enq__v,
        output req_enq__RDY,
        output bscan_enq__ENA, bscan_enq__v,
        input  bscan_enq__RDY,
        input  resp_enq__ENA, resp_enq__v,
        output resp_enq__RDY,
        output rsp_enq__ENA, rsp_enq__v,
        input  rsp_enq__RDY
    );

    modport master (
        output req_enq__ENA, req_enq__v,
        input  req_enq__RDY,
        input  bscan_enq__ENA, bscan_enq__v,
        output bscan_enq__RDY,
        output resp_enq__ENA, resp_enq__v,
        input  resp_enq__RDY,
        input  rsp_enq__ENA, rsp_enq__v,
        output rsp_enq__RDY
    );
endinterface

// File: rtl/bscan_arbiter.sv
// bscan_arbiter: round-robin sharing of one Bscan transaction path among
// NUM_REQ requesters, one transaction outstanding at a time.
// Optional WAIT-state watchdog: define BSCAN_ARB_TIMEOUT_EN to enable it
// (TIMEOUT cycles without a response returns all ones and pulses timeout_err).
module bscan_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                       CLK,
    input  logic                       RST,
    bscan_arbiter_if.slave             bus,
    output logic [$clog2(NUM_REQ)-1:0] owner,
    output logic                       busy,
    output logic                       timeout_err
);
    localparam int OW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_bad_param
        $error("bscan_arbiter: unsupported NUM_REQ or TIMEOUT");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} state_t;

    state_t             state;
    state_t             state_next;
    logic [NUM_REQ-1:0] held;
    logic [WIDTH-1:0]   slot [NUM_REQ];
    logic [OW-1:0]      last;
    logic [WIDTH-1:0]   rsp_word;

    logic [2*NUM_REQ-1:0] held_rot;
    logic [OW-1:0]        first_ofs;
    logic [OW:0]          pick_sum;
    logic [OW-1:0]        pick;
    logic                 pick_vld;

    logic issue_fire;
    logic resp_fire;
    logic deliver_fire;
    logic expire;

    // Handshakes that complete this cycle; nothing fires while RST is high
    // so a reset mid-transaction never leaks an ENA.
    assign issue_fire   = (state == ISSUE) && bus.bscan_enq__RDY && !RST;
    assign resp_fire    = (state == WAIT) && bus.resp_enq__ENA && !RST;
    assign deliver_fire = (state == DELIVER) && bus.rsp_enq__RDY[owner] && !RST;

`ifdef BSCAN_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wait_cnt;

    // A response in the expiry cycle wins over the timeout.
    assign expire = (state == WAIT) && (wait_cnt == CW'(TIMEOUT - 1)) && !bus.resp_enq__ENA && !RST;

    // WAIT-cycle counter, cleared on entry to WAIT.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wait_cnt <= '0;
        end else if (issue_fire) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + CW'(1);
        end
    end

    // Single-cycle pulse marking the cycle after expiry (first DELIVER cycle).
    always_ff @(posedge CLK) begin
        if (RST) begin
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= expire;
        end
    end
`else
    assign expire      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Round-robin pick: rotate held so bit 0 is index last+1, take the lowest
    // set bit, then map the offset back to an absolute index modulo NUM_REQ.
    always_comb begin
        held_rot  = {held, held} >> ({1'b0, last} + {{OW{1'b0}}, 1'b1});
        first_ofs = '0;
        pick_vld  = 1'b0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (held_rot[j]) begin
                first_ofs = OW'(j);
                pick_vld  = 1'b1;
            end
        end
        pick_sum = {1'b0, last} + {1'b0, first_ofs} + {{OW{1'b0}}, 1'b1};
        if (pick_sum >= (OW+1)'(NUM_REQ)) begin
            pick_sum = pick_sum - (OW+1)'(NUM_REQ);
        end
        pick = pick_sum[OW-1:0];
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pick_vld) state_next = ISSUE;
            ISSUE:   if (issue_fire) state_next = WAIT;
            WAIT:    if (resp_fire || expire) state_next = DELIVER;
            DELIVER: if (deliver_fire) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus outputs decoded from the current state and the completing handshakes.
    always_comb begin
        bus.req_enq__RDY   = ~held;
        bus.bscan_enq__ENA = issue_fire;
        bus.bscan_enq__v   = slot[owner];
        bus.resp_enq__RDY  = (state == WAIT) && !RST;
        bus.rsp_enq__ENA   = '0;
        if (deliver_fire) begin
            bus.rsp_enq__ENA[owner] = 1'b1;
        end
        bus.rsp_enq__v     = rsp_word;
        busy               = (state != IDLE);
    end

    // Arbitration bookkeeping: hold flags, grant owner, round-robin pointer
    // and the captured response word.
    always_ff @(posedge CLK) begin
        if (RST) begin
            held     <= '0;
            owner    <= '0;
            last     <= OW'(NUM_REQ - 1);
            rsp_word <= '0;
        end else begin
            if (state == IDLE && pick_vld) begin
                owner <= pick;
            end
            if (deliver_fire) begin
                last <= owner;
            end
            if (resp_fire) begin
                rsp_word <= bus.resp_enq__v;
            end else if (expire) begin
                rsp_word <= '1;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (issue_fire && owner == OW'(i)) begin
                    held[i] <= 1'b0;
                end
                if (bus.req_enq__ENA[i]) begin
                    held[i] <= 1'b1;
                end
            end
        end
    end

    // Hold-slot data capture; contents only matter while held is set.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req_enq__ENA[i]) begin
                slot[i] <= bus.req_enq__v[i*WIDTH +: WIDTH];
            end
        end
    end
endmodule
